// File: rtl/mem_align_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_align_sequencer_if
// Bundles the signals of the MEM-stage alignment sequencer.
//
// Request side (MEM stage -> sequencer):
//   MemRead, MemWrite, Funct3, addr, wdata
// Response side (sequencer -> MEM stage):
//   rdata, stall, done, misaligned_fault
// Data-memory side (sequencer <-> datamemory):
//   dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3 (to memory)
//   dm_rd (combinational read data back from memory)
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment around it (MEM stage plus data memory)
// ---------------------------------------------------------------------------
interface mem_align_sequencer_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            Funct3;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  stall;
    logic                  done;
    logic                  misaligned_fault;
    logic                  dm_MemRead;
    logic                  dm_MemWrite;
    logic [DM_ADDRESS-1:0] dm_a;
    logic [DATA_W-1:0]     dm_wd;
    logic [2:0]            dm_Funct3;
    logic [DATA_W-1:0]     dm_rd;

    modport slave (
        input  MemRead, MemWrite, Funct3, addr, wdata, dm_rd,
        output rdata, stall, done, misaligned_fault,
        output dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3
    );

    modport master (
        output MemRead, MemWrite, Funct3, addr, wdata, dm_rd,
        input  rdata, stall, done, misaligned_fault,
        input  dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3
    );
endinterface

// File: rtl/mem_align_sequencer.sv
// ---------------------------------------------------------------------------
// mem_align_sequencer
// MEM-stage front end sitting directly in front of the data memory.
//   - Aligned loads/stores pass straight through in the same cycle.
//   - Misaligned loads are split into two word reads whose results are
//     merged, shifted and extended.
//   - Misaligned stores are split into a run of byte stores.
//   - stall holds the MEM stage for the whole split sequence; done marks the
//     cycle in which the access completes.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   bus (slave)     - request inputs MemRead/MemWrite/Funct3/addr/wdata,
//                     response outputs rdata/stall/done/misaligned_fault,
//                     data-memory strobes dm_MemRead/dm_MemWrite/dm_a/
//                     dm_wd/dm_Funct3 and combinational read data dm_rd
//
// Build option:
//   MISALIGN_TRAP_EN - when defined, misaligned requests are not split; they
//                      issue nothing and report misaligned_fault for one
//                      cycle. Undefined (default): split behaviour and
//                      misaligned_fault is constant 0.
//
// Address arithmetic wraps modulo 2**DM_ADDRESS. DATA_W must be 32.
// ---------------------------------------------------------------------------
module mem_align_sequencer #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input logic                  clk,
    input logic                  reset,
    mem_align_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_HI   = 2'd1,
        ST_BYTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    // Request captured in IDLE; inputs are ignored while the sequence runs.
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            f3_q;
    logic                  load_q;
    logic                  capture;

`ifdef MISALIGN_TRAP_EN
    logic                  fault_q, fault_d;
`endif

    // Misalignment only exists for half (x01) and word (x10) sizes.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo2);
        logic mis;
        mis = 1'b0;
        if (f3[1:0] == 2'b01 && lo2 == 2'b11)
            mis = 1'b1;
        if (f3[1:0] == 2'b10 && lo2 != 2'b00)
            mis = 1'b1;
        return mis;
    endfunction

    // Size-truncate and extend the merged load data: LH sign, LHU zero, LW as-is.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] m,
                                                      input logic [2:0]        f3);
        logic signed [15:0]       half_s;
        logic signed [DATA_W-1:0] ext_s;
        logic [DATA_W-1:0]        res;
        half_s = m[15:0];
        ext_s  = half_s;
        case (f3)
            3'b001:  res = ext_s;
            3'b101:  res = {{(DATA_W-16){1'b0}}, m[15:0]};
            default: res = m;
        endcase
        return res;
    endfunction

    logic                  req_valid;
    logic                  req_load;
    logic                  req_mis;
    logic [DM_ADDRESS-1:0] req_base;
    logic [DM_ADDRESS-1:0] hi_addr;
    logic [DM_ADDRESS-1:0] byte_addr;
    logic [7:0]            byte_data;
    logic [1:0]            last_cnt;
    logic [DATA_W-1:0]     merged;

    assign req_valid = bus.MemRead | bus.MemWrite;
    assign req_load  = bus.MemRead;                // MemRead wins when both are high
    assign req_mis   = is_misaligned(bus.Funct3, bus.addr[1:0]);
    assign req_base  = {bus.addr[DM_ADDRESS-1:2], 2'b00};

    // Second word of a split load; the +4 wraps at the top of memory.
    assign hi_addr   = {addr_q[DM_ADDRESS-1:2], 2'b00} + DM_ADDRESS'(4);
    assign byte_addr = addr_q + DM_ADDRESS'(cnt_q);
    assign byte_data = wdata_q[{cnt_q, 3'b000} +: 8];
    assign last_cnt  = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

    // {high word, low word} shifted down to the requested byte offset.
    assign merged = DATA_W'({bus.dm_rd, lo_q} >> {addr_q[1:0], 3'b000});

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            lo_q    <= '0;
            rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            fault_q <= fault_d;
`endif
        end
    end

    // Request capture (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            f3_q    <= bus.Funct3;
            load_q  <= req_load;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        lo_d                 = lo_q;
        rdata_d              = rdata_q;
        capture              = 1'b0;
`ifdef MISALIGN_TRAP_EN
        fault_d              = 1'b0;
`endif
        bus.rdata            = '0;
        bus.stall            = 1'b0;
        bus.done             = 1'b0;
        bus.misaligned_fault = 1'b0;
        bus.dm_MemRead       = 1'b0;
        bus.dm_MemWrite      = 1'b0;
        bus.dm_a             = '0;
        bus.dm_wd            = '0;
        bus.dm_Funct3        = 3'b000;

        // While reset is high every output stays at zero.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        capture = 1'b1;
                        if (!req_mis) begin
                            bus.dm_MemRead  = req_load;
                            bus.dm_MemWrite = ~req_load;
                            bus.dm_a        = bus.addr;
                            bus.dm_wd       = bus.wdata;
                            bus.dm_Funct3   = bus.Funct3;
                            bus.rdata       = bus.dm_rd;
                            bus.done        = 1'b1;
                        end else begin
                            bus.stall = 1'b1;
`ifdef MISALIGN_TRAP_EN
                            fault_d = 1'b1;
                            state_d = DONE;
`else
                            if (req_load) begin
                                bus.dm_MemRead = 1'b1;
                                bus.dm_a       = req_base;
                                bus.dm_Funct3  = F3_WORD;
                                lo_d           = bus.dm_rd;
                                state_d        = LD_HI;
                            end else begin
                                bus.dm_MemWrite = 1'b1;
                                bus.dm_a        = bus.addr;
                                bus.dm_wd       = {{(DATA_W-8){1'b0}}, bus.wdata[7:0]};
                                bus.dm_Funct3   = F3_BYTE;
                                cnt_d           = 2'd1;
                                state_d         = ST_BYTE;
                            end
`endif
                        end
                    end
                end

                LD_HI: begin
                    bus.stall      = 1'b1;
                    bus.dm_MemRead = 1'b1;
                    bus.dm_a       = hi_addr;
                    bus.dm_Funct3  = F3_WORD;
                    rdata_d        = load_extend(merged, f3_q);
                    state_d        = DONE;
                end

                ST_BYTE: begin
                    bus.stall       = 1'b1;
                    bus.dm_MemWrite = 1'b1;
                    bus.dm_a        = byte_addr;
                    bus.dm_wd       = {{(DATA_W-8){1'b0}}, byte_data};
                    bus.dm_Funct3   = F3_BYTE;
                    if (cnt_q == last_cnt)
                        state_d = DONE;
                    else
                        cnt_d = cnt_q + 2'd1;
                end

                DONE: begin
                    bus.done  = 1'b1;
                    bus.rdata = load_q ? rdata_q : '0;
`ifdef MISALIGN_TRAP_EN
                    if (fault_q) begin
                        bus.misaligned_fault = 1'b1;
                        bus.rdata            = '0;
                    end
`endif
                    state_d = IDLE;
                end

                default: state_d = IDLE;
            endcase
        end
    end

endmodule
